// File: rtl/alu_pkg.sv
// Function codes and data width shared by the execute-stage ALU and the decoder.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_XNOR = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b1100;
   localparam logic [3:0] ALU_SLT  = 4'b1101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;

endpackage

// File: rtl/alu_addsub.sv
// Shared 33-bit adder/subtractor: a + (b ^ {sub}) + sub, with carry-out and signed overflow.
module alu_addsub
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] sum,
   output logic              carry_out,
   output logic              ovf
);

   logic [DATA_W-1:0] w_b;
   logic [DATA_W:0]   w_full;

   assign w_b    = b ^ {DATA_W{sub}};
   assign w_full = {1'b0, a} + {1'b0, w_b} + {{DATA_W{1'b0}}, sub};

   assign sum       = w_full[DATA_W-1:0];
   assign carry_out = w_full[DATA_W];
   // Using the inverted b makes one rule cover both add and subtract overflow.
   assign ovf       = (a[DATA_W-1] == w_b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Registered 32-bit MIPS execute-stage ALU; one-cycle latency, new op every cycle.
// Optional ALU_OVF_EN adds a registered signed-overflow flag for ADD/SUB.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [3:0]        func,
`ifdef ALU_OVF_EN
   output logic              overflow,
`endif
   output logic [DATA_W-1:0] aluout
);

   logic              w_sub;
   logic [DATA_W-1:0] w_sum;
   logic              w_carry;
   logic              w_ovf;
   logic [DATA_W-1:0] w_result;
   logic [DATA_W-1:0] r_aluout;

   assign w_sub = (func == ALU_SUB) || (func == ALU_SLT) || (func == ALU_SLTU);

   alu_addsub u_addsub (
      .a         (in1),
      .b         (in2),
      .sub       (w_sub),
      .sum       (w_sum),
      .carry_out (w_carry),
      .ovf       (w_ovf)
   );

   always_comb begin
      w_result = '0;
      case (func)
         ALU_AND:  w_result = in1 & in2;
         ALU_OR:   w_result = in1 | in2;
         ALU_XOR:  w_result = in1 ^ in2;
         ALU_XNOR: w_result = ~(in1 ^ in2);
         ALU_ADD:  w_result = w_sum;
         ALU_SUB:  w_result = w_sum;
         // Sign of the difference is wrong exactly when the subtraction overflowed.
         ALU_SLT:  w_result = {{(DATA_W-1){1'b0}}, w_sum[DATA_W-1] ^ w_ovf};
         ALU_SLTU: w_result = {{(DATA_W-1){1'b0}}, ~w_carry};
         default:  w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aluout <= '0;
      end else begin
         r_aluout <= w_result;
      end
   end

   assign aluout = r_aluout;

`ifdef ALU_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= ((func == ALU_ADD) || (func == ALU_SUB)) && w_ovf;
      end
   end

   assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against a behavioural model.
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic [3:0]  func = '0;
   logic [31:0] aluout;
`ifdef ALU_OVF_EN
   logic        overflow;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu dut (
      .clk      (clk),
      .reset    (reset),
      .in1      (in1),
      .in2      (in2),
      .func     (func),
`ifdef ALU_OVF_EN
      .overflow (overflow),
`endif
      .aluout   (aluout)
   );

   // Reference model: plain arithmetic on the operation definitions.
   function automatic logic [31:0] model_res(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (f)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a ^ b;
         4'b0011: return ~(a ^ b);
         4'b0100: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         4'b1100: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
         4'b1101: return (sa < sb) ? 32'd1 : 32'd0;
         4'b0110: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_ovf(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      if (f == 4'b0100)      r = sa + sb;
      else if (f == 4'b1100) r = sa - sb;
      else                   return 1'b0;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic apply(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      func = f;
      in1  = a;
      in2  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      apply(ALU_OR, 32'hFFFF_FFFF, 32'h0);
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_hold: got %h expected %h", aluout, 32'h0);
      end
`ifdef ALU_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ovf: got %b expected 0", overflow);
      end
`endif
      reset = 1'b0;
      apply(ALU_OR, 32'hFFFF_FFFF, 32'h0);
      tests_run++;
      if (aluout !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL reset_release: got %h expected %h", aluout, 32'hFFFF_FFFF);
      end
      // Reset mid-stream discards the in-flight overflowing add.
      func = ALU_ADD; in1 = 32'h7FFF_FFFF; in2 = 32'h1; reset = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_midstream: got %h expected %h", aluout, 32'h0);
      end
`ifdef ALU_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_midstream_ovf: got %b expected 0", overflow);
      end
`endif
      reset = 1'b0;
      $display("[TB] reset done");
   endtask

   task automatic test_logic();
      logic [3:0]  codes [4] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR};
      logic [31:0] exp   [4] = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'hFF00_00FF};
      for (int i = 0; i < 4; i++) begin
         apply(codes[i], 32'hFFFF_0000, 32'hFF00_FF00);
         tests_run++;
         if (aluout !== exp[i]) begin
            tests_failed++;
            $display("FAIL logic_%0d: got %h expected %h", i, aluout, exp[i]);
         end
         $display("[TB] logic func=%b out=%h", codes[i], aluout);
      end
   endtask

   task automatic test_arith();
      apply(ALU_ADD, 32'd78375, 32'd42596);
      tests_run++;
      if (aluout !== 32'h0001_D88B) begin
         tests_failed++;
         $display("FAIL add: got %h expected %h", aluout, 32'h0001_D88B);
      end
      apply(ALU_SUB, 32'd78375, 32'd42596);
      tests_run++;
      if (aluout !== 32'h0000_8BC3) begin
         tests_failed++;
         $display("FAIL sub: got %h expected %h", aluout, 32'h0000_8BC3);
      end
      apply(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL add_wrap: got %h expected %h", aluout, 32'h0);
      end
`ifdef ALU_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_wrap_ovf: got %b expected 0", overflow);
      end
`endif
      $display("[TB] arith done");
   endtask

   task automatic test_compare();
      apply(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_000F);
      tests_run++;
      if (aluout !== 32'h1) begin
         tests_failed++;
         $display("FAIL slt_neg: got %h expected %h", aluout, 32'h1);
      end
      apply(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_000F);
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL sltu_big: got %h expected %h", aluout, 32'h0);
      end
      apply(ALU_SLT, 32'h8000_0000, 32'h1);
      tests_run++;
      if (aluout !== 32'h1) begin
         tests_failed++;
         $display("FAIL slt_min: got %h expected %h", aluout, 32'h1);
      end
      apply(ALU_SLTU, 32'h8000_0000, 32'h1);
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL sltu_min: got %h expected %h", aluout, 32'h0);
      end
      $display("[TB] compare done");
   endtask

   task automatic test_overflow();
      apply(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
      tests_run++;
      if (aluout !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL ovf_add_res: got %h expected %h", aluout, 32'h8000_0000);
      end
`ifdef ALU_OVF_EN
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_add_flag: got %b expected 1", overflow);
      end
`endif
      apply(ALU_SUB, 32'h8000_0000, 32'h1);
      tests_run++;
      if (aluout !== 32'h7FFF_FFFF) begin
         tests_failed++;
         $display("FAIL ovf_sub_res: got %h expected %h", aluout, 32'h7FFF_FFFF);
      end
`ifdef ALU_OVF_EN
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sub_flag: got %b expected 1", overflow);
      end
`endif
      apply(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
      tests_run++;
      if (aluout !== 32'h0) begin
         tests_failed++;
         $display("FAIL unused_code: got %h expected %h", aluout, 32'h0);
      end
      $display("[TB] overflow/unused done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] prev;
      logic [31:0] a, b, exp;
      logic [3:0]  f;
      prev = aluout;
      for (int i = 0; i < 16; i++) begin
         f = 4'(i);
         a = pick_operand();
         b = pick_operand();
         exp = model_res(f, a, b);
         func = f; in1 = a; in2 = b;
         #1;
         tests_run++;
         if (aluout !== prev) begin
            tests_failed++;
            $display("FAIL b2b_hold_%0d: got %h expected %h", i, aluout, prev);
         end
         @(posedge clk); #1;
         tests_run++;
         if (aluout !== exp) begin
            tests_failed++;
            $display("FAIL b2b_%0d: got %h expected %h", i, aluout, exp);
         end
         prev = exp;
      end
      $display("[TB] back-to-back done");
   endtask

   task automatic test_random();
      logic [31:0] a, b, exp;
      logic [3:0]  f;
      for (int i = 0; i < 200; i++) begin
         f = 4'($urandom_range(0, 15));
         a = pick_operand();
         b = pick_operand();
         exp = model_res(f, a, b);
         apply(f, a, b);
         tests_run++;
         if (aluout !== exp) begin
            tests_failed++;
            $display("FAIL rand_res f=%b a=%h b=%h: got %h expected %h", f, a, b, aluout, exp);
         end
`ifdef ALU_OVF_EN
         tests_run++;
         if (overflow !== model_ovf(f, a, b)) begin
            tests_failed++;
            $display("FAIL rand_ovf f=%b a=%h b=%h: got %b expected %b", f, a, b, overflow, model_ovf(f, a, b));
         end
`endif
         $display("[TB] txn %0d f=%b a=%h b=%h out=%h ovf_ref=%b", i, f, a, b, aluout, model_ovf(f, a, b));
      end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_arith();
      test_compare();
      test_overflow();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
